// File: rtl/arp_eth_tx.sv
// ARP frame transmitter: latches a full ARP frame, offers the Ethernet header
// on a parallel handshake and streams the 28-byte ARP payload over AXI-stream.
module arp_eth_tx #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  s_frame_valid,
    output logic                  s_frame_ready,
    input  logic [47:0]           s_eth_dest_mac,
    input  logic [47:0]           s_eth_src_mac,
    input  logic [15:0]           s_eth_type,
    input  logic [15:0]           s_arp_htype,
    input  logic [15:0]           s_arp_ptype,
    input  logic [15:0]           s_arp_oper,
    input  logic [47:0]           s_arp_sha,
    input  logic [31:0]           s_arp_spa,
    input  logic [47:0]           s_arp_tha,
    input  logic [31:0]           s_arp_tpa,

    output logic                  m_eth_hdr_valid,
    input  logic                  m_eth_hdr_ready,
    output logic [47:0]           m_eth_dest_mac,
    output logic [47:0]           m_eth_src_mac,
    output logic [15:0]           m_eth_type,
    output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
    output logic                  m_eth_payload_axis_tvalid,
    input  logic                  m_eth_payload_axis_tready,
    output logic                  m_eth_payload_axis_tlast,
    output logic                  m_eth_payload_axis_tuser,

    output logic                  busy
);

    localparam int CYCLE_COUNT = (28 + KEEP_WIDTH - 1) / KEEP_WIDTH;
    localparam int PTR_W = (CYCLE_COUNT > 1) ? $clog2(CYCLE_COUNT) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CYCLE_COUNT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  frame_ready_q, frame_ready_d;
    logic                  hdr_valid_q, hdr_valid_d;
    logic [47:0]           dest_q, dest_d;
    logic [47:0]           src_q, src_d;
    logic [15:0]           type_q, type_d;
    logic [223:0]          payload_q, payload_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  busy_q, busy_d;

    logic                  accept;
    logic                  beat;
    logic [223:0]          pay_in;
    logic [223:0]          word_src;
    int                    word_idx;
    int                    byte_idx;
    logic [DATA_WIDTH-1:0] word_data;
    logic [KEEP_WIDTH-1:0] word_keep;
    logic                  word_last;

    // Payload held big-endian: byte 0 of the ARP payload is the top byte.
    assign pay_in = {s_arp_htype, s_arp_ptype, 8'h06, 8'h04, s_arp_oper,
                     s_arp_sha, s_arp_spa, s_arp_tha, s_arp_tpa};

    always_comb begin
        accept = frame_ready_q && s_frame_valid;
        beat   = tvalid_q && m_eth_payload_axis_tready;

        word_src = payload_q;
        word_idx = int'(ptr_q) + 1;
        if (accept) begin
            word_src = pay_in;
            word_idx = 0;
        end

        word_data = '0;
        word_keep = '0;
        byte_idx  = 0;
        for (int l = 0; l < KEEP_WIDTH; l++) begin
            byte_idx = word_idx * KEEP_WIDTH + l;
            if (byte_idx < 28) begin
                word_data[l*8 +: 8] = word_src[(27 - byte_idx) * 8 +: 8];
                word_keep[l]        = 1'b1;
            end
        end
        word_last = (word_idx == CYCLE_COUNT - 1);

        state_d     = state_q;
        ptr_d       = ptr_q;
        hdr_valid_d = hdr_valid_q;
        dest_d      = dest_q;
        src_d       = src_q;
        type_d      = type_q;
        payload_d   = payload_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;

        if (hdr_valid_q && m_eth_hdr_ready) begin
            hdr_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_SEND;
                    ptr_d       = '0;
                    hdr_valid_d = 1'b1;
                    dest_d      = s_eth_dest_mac;
                    src_d       = s_eth_src_mac;
                    type_d      = s_eth_type;
                    payload_d   = pay_in;
                    tdata_d     = word_data;
                    tkeep_d     = word_keep;
                    tvalid_d    = 1'b1;
                    tlast_d     = word_last;
                end
            end
            ST_SEND: begin
                if (beat) begin
                    if (ptr_q == PTR_LAST) begin
                        state_d  = ST_IDLE;
                        tdata_d  = '0;
                        tkeep_d  = '0;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end else begin
                        ptr_d   = ptr_q + PTR_W'(1);
                        tdata_d = word_data;
                        tkeep_d = word_keep;
                        tlast_d = word_last;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d        = (state_d == ST_SEND);
        frame_ready_d = (state_d == ST_IDLE) && !hdr_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            frame_ready_q <= 1'b0;
            hdr_valid_q   <= 1'b0;
            dest_q        <= '0;
            src_q         <= '0;
            type_q        <= '0;
            payload_q     <= '0;
            tdata_q       <= '0;
            tkeep_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            frame_ready_q <= frame_ready_d;
            hdr_valid_q   <= hdr_valid_d;
            dest_q        <= dest_d;
            src_q         <= src_d;
            type_q        <= type_d;
            payload_q     <= payload_d;
            tdata_q       <= tdata_d;
            tkeep_q       <= tkeep_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            busy_q        <= busy_d;
        end
    end

    assign s_frame_ready             = frame_ready_q;
    assign m_eth_hdr_valid           = hdr_valid_q;
    assign m_eth_dest_mac            = dest_q;
    assign m_eth_src_mac             = src_q;
    assign m_eth_type                = type_q;
    assign m_eth_payload_axis_tdata  = tdata_q;
    assign m_eth_payload_axis_tkeep  = (KEEP_ENABLE != 0) ? tkeep_q
                                                          : {KEEP_WIDTH{1'b1}};
    assign m_eth_payload_axis_tvalid = tvalid_q;
    assign m_eth_payload_axis_tlast  = tlast_q;
    assign m_eth_payload_axis_tuser  = 1'b0;
    assign busy                      = busy_q;

endmodule

// File: tb/tb_arp_eth_tx.sv
// Directed bench for arp_eth_tx: 8-bit frames from a vector table plus
// back-to-back, mid-frame reset and a 64-bit instance.
module tb_arp_eth_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [47:0] f_dmac, f_smac, f_sha, f_tha;
    logic [15:0] f_etype, f_htype, f_ptype, f_oper;
    logic [31:0] f_spa, f_tpa;

    logic        s_frame_valid, s_frame_ready;
    logic        hdr_valid, hdr_ready;
    logic [47:0] o_dmac, o_smac;
    logic [15:0] o_etype;
    logic [7:0]  tdata;
    logic [0:0]  tkeep;
    logic        tvalid, tready, tlast, tuser, busy;

    logic        w_valid, w_ready;
    logic        w_hdr_valid, w_hdr_ready;
    logic [47:0] w_dmac, w_smac;
    logic [15:0] w_etype;
    logic [63:0] w_tdata;
    logic [7:0]  w_tkeep;
    logic        w_tvalid, w_tready, w_tlast, w_tuser, w_busy;

    arp_eth_tx #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .s_frame_valid(s_frame_valid), .s_frame_ready(s_frame_ready),
        .s_eth_dest_mac(f_dmac), .s_eth_src_mac(f_smac),
        .s_eth_type(f_etype), .s_arp_htype(f_htype),
        .s_arp_ptype(f_ptype), .s_arp_oper(f_oper),
        .s_arp_sha(f_sha), .s_arp_spa(f_spa),
        .s_arp_tha(f_tha), .s_arp_tpa(f_tpa),
        .m_eth_hdr_valid(hdr_valid), .m_eth_hdr_ready(hdr_ready),
        .m_eth_dest_mac(o_dmac), .m_eth_src_mac(o_smac),
        .m_eth_type(o_etype),
        .m_eth_payload_axis_tdata(tdata),
        .m_eth_payload_axis_tkeep(tkeep),
        .m_eth_payload_axis_tvalid(tvalid),
        .m_eth_payload_axis_tready(tready),
        .m_eth_payload_axis_tlast(tlast),
        .m_eth_payload_axis_tuser(tuser),
        .busy(busy)
    );

    arp_eth_tx #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .s_frame_valid(w_valid), .s_frame_ready(w_ready),
        .s_eth_dest_mac(f_dmac), .s_eth_src_mac(f_smac),
        .s_eth_type(f_etype), .s_arp_htype(f_htype),
        .s_arp_ptype(f_ptype), .s_arp_oper(f_oper),
        .s_arp_sha(f_sha), .s_arp_spa(f_spa),
        .s_arp_tha(f_tha), .s_arp_tpa(f_tpa),
        .m_eth_hdr_valid(w_hdr_valid), .m_eth_hdr_ready(w_hdr_ready),
        .m_eth_dest_mac(w_dmac), .m_eth_src_mac(w_smac),
        .m_eth_type(w_etype),
        .m_eth_payload_axis_tdata(w_tdata),
        .m_eth_payload_axis_tkeep(w_tkeep),
        .m_eth_payload_axis_tvalid(w_tvalid),
        .m_eth_payload_axis_tready(w_tready),
        .m_eth_payload_axis_tlast(w_tlast),
        .m_eth_payload_axis_tuser(w_tuser),
        .busy(w_busy)
    );

    typedef struct {
        logic [47:0]  dmac;
        logic [47:0]  smac;
        logic [15:0]  etype;
        logic [15:0]  htype;
        logic [15:0]  ptype;
        logic [15:0]  oper;
        logic [47:0]  sha;
        logic [31:0]  spa;
        logic [47:0]  tha;
        logic [31:0]  tpa;
        logic [223:0] exp;
        int           bp;
        int           hold;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } w_t;

    vec_t vecs[4];
    w_t   wt[4];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gb(input logic [223:0] p, input int i);
        return p[(27 - i) * 8 +: 8];
    endfunction

    task automatic set_fields(input vec_t v);
        f_dmac  = v.dmac;
        f_smac  = v.smac;
        f_etype = v.etype;
        f_htype = v.htype;
        f_ptype = v.ptype;
        f_oper  = v.oper;
        f_sha   = v.sha;
        f_spa   = v.spa;
        f_tha   = v.tha;
        f_tpa   = v.tpa;
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int nb = 0;
        int cyc = 0;
        int since = 0;
        int hdr_cnt = 0;
        int acc_cyc = 0;
        int last_cyc = 0;
        bit acc = 0;
        bit taken = 0;
        bit bfire, hfire, afire;
        set_fields(v);
        s_frame_valid = 1'b1;
        while (cyc < 300 && !(acc && nb == 28 && taken)) begin
            tready    = (v.bp == 0) ? 1'b1 : ((cyc % 2) == 0);
            hdr_ready = acc && (since >= v.hold);
            if (acc) begin
                chk({tag, " busy"}, 64'(busy), 64'(nb < 28));
                chk({tag, " tvalid"}, 64'(tvalid), 64'(nb < 28));
                chk({tag, " hdr_valid"}, 64'(hdr_valid), 64'(!taken));
                chk({tag, " s_ready"}, 64'(s_frame_ready),
                    64'(nb == 28 && taken));
                if (tvalid && nb < 28) begin
                    chk($sformatf("%s byte%0d", tag, nb), 64'(tdata),
                        64'(gb(v.exp, nb)));
                    chk($sformatf("%s last%0d", tag, nb), 64'(tlast),
                        64'(nb == 27));
                    chk({tag, " tuser"}, 64'(tuser), 64'd0);
                    chk({tag, " tkeep"}, 64'(tkeep), 64'd1);
                end
            end
            bfire = acc && tvalid && tready;
            hfire = hdr_valid && hdr_ready;
            afire = !acc && s_frame_valid && s_frame_ready;
            if (hfire) begin
                hdr_cnt++;
                chk({tag, " dmac"}, 64'(o_dmac), 64'(v.dmac));
                chk({tag, " smac"}, 64'(o_smac), 64'(v.smac));
                chk({tag, " etype"}, 64'(o_etype), 64'(v.etype));
            end
            @(posedge clk);
            #1;
            cyc++;
            if (afire) begin
                acc = 1;
                since = 0;
                s_frame_valid = 1'b0;
                acc_cyc = cyc;
            end else if (acc) begin
                since++;
            end
            if (bfire) begin
                nb++;
                if (nb == 28) last_cyc = cyc;
            end
            if (hfire) taken = 1;
        end
        s_frame_valid = 1'b0;
        chk({tag, " complete"}, 64'(acc && nb == 28 && taken), 64'd1);
        chk({tag, " hdr_count"}, 64'(hdr_cnt), 64'd1);
        chk({tag, " ready_end"}, 64'(s_frame_ready), 64'd1);
        chk({tag, " busy_end"}, 64'(busy), 64'd0);
        if (v.bp == 0 && v.hold == 0) begin
            chk({tag, " latency"}, 64'(last_cyc - acc_cyc), 64'd28);
        end
    endtask

    logic [7:0]   bq[$];
    logic         lq[$];
    logic [223:0] exp1;
    int           ac[2];
    int           nacc, nb, cyc, acc_cyc, last_cyc;
    bit           bfire, afire;

    initial begin
        vecs[0] = '{dmac: 48'hFFFFFFFFFFFF, smac: 48'h5A5152535455,
                    etype: 16'h0806, htype: 16'h0001, ptype: 16'h0800,
                    oper: 16'h0002, sha: 48'h5A5152535455,
                    spa: 32'hC0A80180, tha: 48'hDAD1D2D3D4D5,
                    tpa: 32'hC0A80164,
                    exp: 224'h0001_0800_0604_0002_5A5152535455_C0A80180_DAD1D2D3D4D5_C0A80164,
                    bp: 0, hold: 0};
        vecs[1] = vecs[0];
        vecs[1].dmac = 48'h0A0B0C0D0E0F;
        vecs[1].bp = 1;
        vecs[2] = '{dmac: 48'h665544332211, smac: 48'h112233445566,
                    etype: 16'h0806, htype: 16'hABCD, ptype: 16'h1234,
                    oper: 16'hFFFF, sha: 48'h112233445566,
                    spa: 32'h778899AA, tha: 48'hBBCCDDEEFF00,
                    tpa: 32'h01020304,
                    exp: 224'hABCD_1234_0604_FFFF_112233445566_778899AA_BBCCDDEEFF00_01020304,
                    bp: 0, hold: 40};
        vecs[3] = '{dmac: 48'h020000000002, smac: 48'h020000000001,
                    etype: 16'h0806, htype: 16'h0001, ptype: 16'h0800,
                    oper: 16'h0001, sha: 48'h020000000001,
                    spa: 32'h0A000001, tha: 48'h000000000000,
                    tpa: 32'h0A000002,
                    exp: 224'h0001_0800_0604_0001_020000000001_0A000001_000000000000_0A000002,
                    bp: 1, hold: 3};
        wt[0] = '{data: 64'h0200_0406_0008_0100, keep: 8'hFF, last: 1'b0};
        wt[1] = '{data: 64'hA8C0_5554_5352_515A, keep: 8'hFF, last: 1'b0};
        wt[2] = '{data: 64'hD5D4_D3D2_D1DA_8001, keep: 8'hFF, last: 1'b0};
        wt[3] = '{data: 64'h0000_0000_6401_A8C0, keep: 8'h0F, last: 1'b1};

        rst_n = 1'b0;
        s_frame_valid = 1'b0;
        hdr_ready = 1'b0;
        tready = 1'b0;
        w_valid = 1'b0;
        w_hdr_ready = 1'b0;
        w_tready = 1'b0;
        set_fields(vecs[0]);

        repeat (2) @(posedge clk);
        #1;
        chk("rst s_ready", 64'(s_frame_ready), 64'd0);
        chk("rst hdr_valid", 64'(hdr_valid), 64'd0);
        chk("rst tvalid", 64'(tvalid), 64'd0);
        chk("rst tlast", 64'(tlast), 64'd0);
        chk("rst tuser", 64'(tuser), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst tdata", 64'(tdata), 64'd0);
        chk("rst dmac", 64'(o_dmac), 64'd0);
        chk("rst w_tkeep", 64'(w_tkeep), 64'd0);
        chk("rst w_tdata", w_tdata, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel s_ready", 64'(s_frame_ready), 64'd1);
        chk("rel w_ready", 64'(w_ready), 64'd1);

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i], $sformatf("v%0d", i));
        end

        // Back-to-back: valid held high across two frames.
        exp1 = vecs[0].exp;
        exp1[(27 - 7) * 8 +: 8] = 8'h01;
        set_fields(vecs[0]);
        f_oper = 16'h0001;
        s_frame_valid = 1'b1;
        tready = 1'b1;
        hdr_ready = 1'b1;
        nacc = 0;
        for (int c = 0; c < 80; c++) begin
            bfire = tvalid && tready;
            afire = s_frame_valid && s_frame_ready;
            if (bfire) begin
                bq.push_back(tdata);
                lq.push_back(tlast);
            end
            @(posedge clk);
            #1;
            if (afire) begin
                if (nacc < 2) ac[nacc] = c;
                nacc++;
                if (nacc == 1) f_oper = 16'h0002;
                else s_frame_valid = 1'b0;
            end
        end
        s_frame_valid = 1'b0;
        chk("b2b accepts", 64'(nacc), 64'd2);
        chk("b2b gap", 64'(ac[1] - ac[0]), 64'd29);
        chk("b2b beats", 64'(bq.size()), 64'd56);
        for (int i = 0; i < 56; i++) begin
            if (i < bq.size()) begin
                chk($sformatf("b2b byte%0d", i), 64'(bq[i]),
                    64'((i < 28) ? gb(exp1, i) : gb(vecs[0].exp, i - 28)));
                chk($sformatf("b2b last%0d", i), 64'(lq[i]),
                    64'(i == 27 || i == 55));
            end
        end

        // Reset after ten beats with the header still pending.
        set_fields(vecs[0]);
        s_frame_valid = 1'b1;
        tready = 1'b1;
        hdr_ready = 1'b0;
        nb = 0;
        cyc = 0;
        while (cyc < 60 && nb < 10) begin
            bfire = tvalid && tready;
            afire = s_frame_valid && s_frame_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (afire) s_frame_valid = 1'b0;
            if (bfire) nb++;
        end
        chk("mid beats", 64'(nb), 64'd10);
        chk("mid hdr_valid", 64'(hdr_valid), 64'd1);
        chk("mid tvalid", 64'(tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst tvalid", 64'(tvalid), 64'd0);
        chk("mrst hdr_valid", 64'(hdr_valid), 64'd0);
        chk("mrst busy", 64'(busy), 64'd0);
        chk("mrst tlast", 64'(tlast), 64'd0);
        chk("mrst s_ready", 64'(s_frame_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst ready_after", 64'(s_frame_ready), 64'd1);
        run_frame(vecs[0], "post_rst");

        // 64-bit instance.
        set_fields(vecs[0]);
        w_valid = 1'b1;
        w_tready = 1'b1;
        w_hdr_ready = 1'b1;
        nb = 0;
        cyc = 0;
        acc_cyc = 0;
        last_cyc = 0;
        while (cyc < 40 && nb < 4) begin
            if (w_tvalid) begin
                chk($sformatf("w data%0d", nb), w_tdata, wt[nb].data);
                chk($sformatf("w keep%0d", nb), 64'(w_tkeep), 64'(wt[nb].keep));
                chk($sformatf("w last%0d", nb), 64'(w_tlast), 64'(wt[nb].last));
                chk("w tuser", 64'(w_tuser), 64'd0);
            end
            bfire = w_tvalid && w_tready;
            afire = w_valid && w_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (afire) begin
                w_valid = 1'b0;
                acc_cyc = cyc;
            end
            if (bfire) begin
                nb++;
                if (nb == 4) last_cyc = cyc;
            end
        end
        w_valid = 1'b0;
        chk("w beats", 64'(nb), 64'd4);
        chk("w latency", 64'(last_cyc - acc_cyc), 64'd4);
        chk("w busy_end", 64'(w_busy), 64'd0);
        chk("w hdr_end", 64'(w_hdr_valid), 64'd0);
        chk("w dmac", 64'(w_dmac), 64'(vecs[0].dmac));
        chk("w ready_end", 64'(w_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
